// File: rtl/sixteen_bit_adder.sv
// ============================================================================
// sixteen_bit_adder
// ----------------------------------------------------------------------------
// Purpose:
//    Registered WIDTH-bit (default 16) binary adder with carry-in and
//    carry-out. It is the arithmetic building block for the LEGv8 PC increment
//    and ALU add paths. The block computes {c_out, sum} = a + b + c_in with an
//    explicit ripple chain of full adders. The result is registered on every
//    rising clock edge, so latency is 1 cycle and throughput is one add per
//    clock. There is no enable and no handshake.
//
// Parameters:
//    WIDTH    operand/sum width in bits (default 16)
//
// Ports:
//    clk      in   1      single clock, all state updates on the rising edge
//    rst_n    in   1      synchronous active-low reset; clears all outputs
//    a        in   WIDTH  operand A (unsigned, two's-complement compatible)
//    b        in   WIDTH  operand B
//    c_in     in   1      carry into bit 0
//    sum      out  WIDTH  registered low WIDTH bits of a + b + c_in
//    c_out    out  1      registered carry out of bit WIDTH-1
//    ovf      out  1      (ADDER_FLAGS_EN only) registered signed overflow
//    zero     out  1      (ADDER_FLAGS_EN only) registered "sum == 0"
//
// Configuration macro:
//    ADDER_FLAGS_EN  when defined, the block adds the registered ovf and zero
//                    outputs. These flags update and reset together with sum.
//                    When the macro is undefined, the ports and their logic
//                    are absent.
// ============================================================================
module sixteen_bit_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
`ifdef ADDER_FLAGS_EN
   output logic             c_out,
   output logic             ovf,
   output logic             zero
`else
   output logic             c_out
`endif
);

   // -------------------------------------------------------------------------
   // Combinational core: ripple chain of WIDTH full adders.
   // The chain is written as a loop over a single running carry bit instead of
   // a carry vector. A carry vector would make each element depend on its
   // neighbour in the same signal, which simulators treat as a false
   // combinational loop. The loop produces the same gates.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sum_d;
   logic             c_out_d;
   logic             carry;

   always_comb begin
      sum_d   = '0;
      carry   = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i] = a[i] ^ b[i] ^ carry;
         carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out_d = carry;
   end

`ifdef ADDER_FLAGS_EN
   // -------------------------------------------------------------------------
   // Flags are derived from the same next-state sum, so they always describe
   // the value that is registered alongside them.
   // Signed overflow only occurs when both operands share a sign and the
   // result's sign differs from it.
   // -------------------------------------------------------------------------
   logic ovf_d;
   logic zero_d;

   always_comb begin
      ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
      zero_d = (sum_d == '0);
   end
`endif

   // -------------------------------------------------------------------------
   // Result registers. Reset has priority over any operand value, so the add
   // presented at a reset edge is discarded.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;

`ifdef ADDER_FLAGS_EN
   logic ovf_q;
   logic zero_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
`endif

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// ============================================================================
// tb_sixteen_bit_adder
// ----------------------------------------------------------------------------
// Self-checking bench for sixteen_bit_adder.
//
// The bench keeps an arithmetic reference model. On every rising edge the
// model takes the operands and forms the 17-bit integer sum. It derives signed
// overflow from the signed integer result range. A single compare process
// checks the DUT against this model on every falling edge once the first reset
// has been seen.
//
// Directed vectors carry hand-computed literals. Each literal is checked
// against both the DUT and the model, which pins the model itself.
//
// Stimulus is driven on the falling edge and results are sampled on the next
// falling edge.
// ============================================================================
module tb_sixteen_bit_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic [15:0] sum;
   logic        c_out;
`ifdef ADDER_FLAGS_EN
   logic        ovf;
   logic        zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sixteen_bit_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .sum   (sum),
`ifdef ADDER_FLAGS_EN
      .c_out (c_out),
      .ovf   (ovf),
      .zero  (zero)
`else
      .c_out (c_out)
`endif
   );

   // -------------------------------------------------------------------------
   // Reference model: plain integer arithmetic, registered on the rising edge.
   // -------------------------------------------------------------------------
   logic        model_valid = 1'b0;
   logic [15:0] exp_sum;
   logic        exp_c;
   logic        exp_ovf;
   logic        exp_zero;

   function automatic logic [16:0] full_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
      int unsigned t;
      t = int'(x) + int'(y) + int'(ci);
      return t[16:0];
   endfunction

   function automatic logic signed_ovf(input logic [15:0] x, input logic [15:0] y,
                                       input logic ci);
      int r;
      r = int'($signed(x)) + int'($signed(y)) + int'(ci);
      return (r > 32767) || (r < -32768);
   endfunction

   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         exp_sum     <= 16'h0000;
         exp_c       <= 1'b0;
         exp_ovf     <= 1'b0;
         exp_zero    <= 1'b0;
         model_valid <= 1'b1;
      end else if (model_valid) begin
         exp_sum  <= full_add(a, b, c_in) & 17'h0FFFF;
         exp_c    <= full_add(a, b, c_in) >> 16;
         exp_ovf  <= signed_ovf(a, b, c_in);
         exp_zero <= (full_add(a, b, c_in) & 17'h0FFFF) == 17'd0;
      end
   end

   // -------------------------------------------------------------------------
   // Compare process: DUT against the model on every falling edge.
   // -------------------------------------------------------------------------
   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (sum !== exp_sum || c_out !== exp_c) begin
            errors++;
            $display("FAIL model_cmp t=%0t a=%h b=%h c_in=%b got sum=%h c_out=%b want sum=%h c_out=%b",
                     $time, a, b, c_in, sum, c_out, exp_sum, exp_c);
         end
`ifdef ADDER_FLAGS_EN
         checks++;
         if (ovf !== exp_ovf || zero !== exp_zero) begin
            errors++;
            $display("FAIL model_flags t=%0t got ovf=%b zero=%b want ovf=%b zero=%b",
                     $time, ovf, zero, exp_ovf, exp_zero);
         end
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Literal check: DUT and model both against hand-computed values.
   // -------------------------------------------------------------------------
   task automatic check_lit(input string name, input logic [15:0] want_sum,
                            input logic want_c, input logic want_ovf,
                            input logic want_zero);
      checks++;
      if (sum !== want_sum || c_out !== want_c) begin
         errors++;
         $display("FAIL %s dut got sum=%h c_out=%b want sum=%h c_out=%b",
                  name, sum, c_out, want_sum, want_c);
      end
      checks++;
      if (exp_sum !== want_sum || exp_c !== want_c) begin
         errors++;
         $display("FAIL %s model got sum=%h c_out=%b want sum=%h c_out=%b",
                  name, exp_sum, exp_c, want_sum, want_c);
      end
`ifdef ADDER_FLAGS_EN
      checks++;
      if (ovf !== want_ovf || zero !== want_zero) begin
         errors++;
         $display("FAIL %s flags got ovf=%b zero=%b want ovf=%b zero=%b",
                  name, ovf, zero, want_ovf, want_zero);
      end
`else
      if (want_ovf === 1'bx || want_zero === 1'bx) begin
         // flags not present in this build
      end
`endif
      $display("txn %-12s a=%h b=%h c_in=%b rst_n=%b -> sum=%h c_out=%b",
               name, a, b, c_in, rst_n, sum, c_out);
   endtask

   // Directed vectors with hand-computed results.
   localparam int NDIR = 6;
   logic [15:0] dir_a    [NDIR] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h0000};
   logic [15:0] dir_b    [NDIR] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h4321, 16'h0000};
   logic        dir_ci   [NDIR] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
   logic [15:0] dir_sum  [NDIR] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h5556, 16'h0000};
   logic        dir_c    [NDIR] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
   logic        dir_ovf  [NDIR] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
   logic        dir_zero [NDIR] = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};

   initial begin
      rst_n = 1'b0;
      a     = 16'h1234;
      b     = 16'h1111;
      c_in  = 1'b0;

      // Reset held for two edges, operands ignored.
      @(negedge clk);
      check_lit("rst_hold1", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_lit("rst_hold2", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Release: the first result appears one edge later.
      rst_n = 1'b1;
      @(negedge clk);
      check_lit("rst_release", 16'h2345, 1'b0, 1'b0, 1'b0);

      // Doubling sweep a = b = i.
      for (int i = 0; i <= 32766; i++) begin
         a    = 16'(i);
         b    = 16'(i);
         c_in = 1'b0;
         @(negedge clk);
         checks++;
         if ({c_out, sum} !== 17'(2 * i)) begin
            errors++;
            $display("FAIL sweep i=%0d got c_out=%b sum=%h want %h", i, c_out, sum, 17'(2 * i));
         end
      end
      $display("txn sweep_end  a=%h b=%h -> sum=%h c_out=%b", a, b, sum, c_out);
      check_lit("sweep_last", 16'hFFFC, 1'b0, 1'b0, 1'b0);

      // Directed boundary vectors.
      for (int k = 0; k < NDIR; k++) begin
         a    = dir_a[k];
         b    = dir_b[k];
         c_in = dir_ci[k];
         @(negedge clk);
         check_lit($sformatf("dir%0d", k), dir_sum[k], dir_c[k], dir_ovf[k], dir_zero[k]);
      end

      // Random back-to-back sweep with one reset edge in the middle.
      for (int k = 0; k < 200; k++) begin
         a     = 16'($urandom);
         b     = 16'($urandom);
         c_in  = 1'($urandom);
         rst_n = (k == 100) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (k == 100) begin
            check_lit("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
         end
      end
      rst_n = 1'b1;
      a     = 16'h0F0F;
      b     = 16'hF0F1;
      c_in  = 1'b0;
      @(negedge clk);
      check_lit("post_rand", 16'h0000, 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the run is clock driven, so this only trips on a stalled bench.
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
